// File: rtl/pov_slice_scheduler.sv
// Rotation-locked slice sequencer: measures the hall index period, divides it into
// angular slices and scans the column pairs of each slice toward the panel shifter.
module pov_slice_scheduler #(
  parameter int ROTATIONAL_RES = 180,
  parameter int SCAN_RATE      = 32,
  parameter int THETA_RES      = 27,
  parameter int CNT_W          = 27
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         hall_in,
  input  logic                         ready_in,
  output logic [THETA_RES-1:0]         theta,
  output logic [$clog2(SCAN_RATE)-1:0] col_num1,
  output logic [$clog2(SCAN_RATE):0]   col_num2,
  output logic                         valid,
  output logic                         slice_start,
  output logic                         locked,
  output logic [15:0]                  overrun_count
);

  localparam int COL_W  = $clog2(SCAN_RATE);
  localparam int DCNT_W = $clog2(CNT_W + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_DIVIDE  = 2'd2;
  localparam logic [1:0] ST_RUN     = 2'd3;

  localparam logic [CNT_W:0]       DIVISOR    = (CNT_W + 1)'(ROTATIONAL_RES);
  localparam logic [THETA_RES-1:0] THETA_LAST = THETA_RES'(ROTATIONAL_RES - 1);
  localparam logic [COL_W-1:0]     COL_LAST   = COL_W'(SCAN_RATE - 1);
  localparam logic [COL_W:0]       COL2_OFS   = (COL_W + 1)'(SCAN_RATE);

  logic                 r_hall_q;
  logic [1:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_div_busy;
  logic [CNT_W-1:0]     r_div_dvd;
  logic [CNT_W-1:0]     r_div_rem;
  logic [CNT_W-2:0]     r_div_quo;
  logic [DCNT_W-1:0]    r_div_cnt;
  logic [CNT_W-1:0]     r_slice_len;
  logic [CNT_W-1:0]     r_len_next;
  logic [CNT_W-1:0]     r_tmr;
  logic [THETA_RES-1:0] r_theta;
  logic                 r_slice_start;
  logic                 r_locked;
  logic                 r_valid;
  logic [COL_W-1:0]     r_col;
  logic [COL_W:0]       r_col2;
  logic [15:0]          r_ovr;

  logic                 w_rise;
  logic                 w_ovf;
  logic                 w_div_start;
  logic                 w_div_done;
  logic [CNT_W:0]       w_rem_sh;
  logic                 w_q_bit;
  logic [CNT_W-1:0]     w_quo_nx;
  logic [CNT_W-1:0]     w_len_new;
  logic [CNT_W-1:0]     w_len_pend;
  logic                 w_tmr_tc;
  logic                 w_valid_nx;
  logic [COL_W-1:0]     w_col_nx;
  logic [15:0]          w_ovr_nx;

  assign w_rise      = hall_in & ~r_hall_q;
  // Losing the index for a whole counter span drops lock from any active state.
  assign w_ovf       = (r_state != ST_IDLE) && (r_cnt == {CNT_W{1'b1}}) && !w_rise;
  assign w_div_start = w_rise && (r_state != ST_IDLE);
  assign w_rem_sh    = {r_div_rem, r_div_dvd[CNT_W-1]};
  assign w_q_bit     = (w_rem_sh >= DIVISOR);
  assign w_quo_nx    = {r_div_quo, w_q_bit};
  assign w_div_done  = r_div_busy && (r_div_cnt == DCNT_W'(1)) && !w_div_start;
  assign w_len_new   = (w_quo_nx == {CNT_W{1'b0}}) ? CNT_W'(1) : w_quo_nx;
  assign w_len_pend  = w_div_done ? w_len_new : r_len_next;
  assign w_tmr_tc    = (r_tmr == (r_slice_len - CNT_W'(1)));

  // Restoring divider: period / ROTATIONAL_RES, one quotient bit per cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in || w_ovf) begin
      r_div_busy <= 1'b0;
      r_div_dvd  <= {CNT_W{1'b0}};
      r_div_rem  <= {CNT_W{1'b0}};
      r_div_quo  <= {(CNT_W - 1){1'b0}};
      r_div_cnt  <= {DCNT_W{1'b0}};
    end else if (w_div_start) begin
      r_div_busy <= 1'b1;
      r_div_dvd  <= r_cnt + CNT_W'(1);
      r_div_rem  <= {CNT_W{1'b0}};
      r_div_quo  <= {(CNT_W - 1){1'b0}};
      r_div_cnt  <= DCNT_W'(CNT_W);
    end else if (r_div_busy) begin
      r_div_dvd  <= {r_div_dvd[CNT_W-2:0], 1'b0};
      r_div_rem  <= w_q_bit ? CNT_W'(w_rem_sh - DIVISOR) : w_rem_sh[CNT_W-1:0];
      r_div_quo  <= w_quo_nx[CNT_W-2:0];
      r_div_cnt  <= r_div_cnt - DCNT_W'(1);
      r_div_busy <= (r_div_cnt != DCNT_W'(1));
    end
  end

  // Lock FSM, period counter and slice timer driving theta.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_hall_q      <= 1'b0;
      r_state       <= ST_IDLE;
      r_cnt         <= {CNT_W{1'b0}};
      r_slice_len   <= CNT_W'(1);
      r_len_next    <= CNT_W'(1);
      r_tmr         <= {CNT_W{1'b0}};
      r_theta       <= {THETA_RES{1'b0}};
      r_slice_start <= 1'b0;
      r_locked      <= 1'b0;
    end else begin
      r_hall_q      <= hall_in;
      r_slice_start <= 1'b0;
      if (w_ovf) begin
        r_state  <= ST_IDLE;
        r_cnt    <= {CNT_W{1'b0}};
        r_locked <= 1'b0;
        r_theta  <= {THETA_RES{1'b0}};
        r_tmr    <= {CNT_W{1'b0}};
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_cnt <= {CNT_W{1'b0}};
            if (w_rise) r_state <= ST_MEASURE;
            else        r_state <= ST_IDLE;
          end
          ST_MEASURE: begin
            if (w_rise) begin
              r_cnt   <= {CNT_W{1'b0}};
              r_state <= ST_DIVIDE;
            end else begin
              r_cnt   <= r_cnt + CNT_W'(1);
            end
          end
          ST_DIVIDE: begin
            r_cnt <= w_rise ? {CNT_W{1'b0}} : r_cnt + CNT_W'(1);
            if (w_div_done) begin
              r_state       <= ST_RUN;
              r_locked      <= 1'b1;
              r_slice_len   <= w_len_new;
              r_len_next    <= w_len_new;
              r_theta       <= {THETA_RES{1'b0}};
              r_tmr         <= {CNT_W{1'b0}};
              r_slice_start <= 1'b1;
            end
          end
          ST_RUN: begin
            r_cnt <= w_rise ? {CNT_W{1'b0}} : r_cnt + CNT_W'(1);
            if (w_div_done) r_len_next <= w_len_new;
            // A fresh slice length only takes effect at a theta update.
            if (w_rise) begin
              r_theta       <= {THETA_RES{1'b0}};
              r_tmr         <= {CNT_W{1'b0}};
              r_slice_start <= 1'b1;
              r_slice_len   <= w_len_pend;
            end else if (w_tmr_tc) begin
              r_tmr <= {CNT_W{1'b0}};
              if (r_theta != THETA_LAST) begin
                r_theta       <= r_theta + THETA_RES'(1);
                r_slice_start <= 1'b1;
                r_slice_len   <= w_len_pend;
              end
            end else begin
              r_tmr <= r_tmr + CNT_W'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Next state of the column-pair scan, including overrun on aborted scans.
  always_comb begin
    w_valid_nx = r_valid;
    w_col_nx   = r_col;
    w_ovr_nx   = r_ovr;
    if (w_ovf) begin
      w_valid_nx = 1'b0;
      w_col_nx   = {COL_W{1'b0}};
    end else if (r_slice_start) begin
      if (r_valid && !(ready_in && (r_col == COL_LAST)) && (r_ovr != 16'hFFFF)) begin
        w_ovr_nx = r_ovr + 16'd1;
      end else begin
        w_ovr_nx = r_ovr;
      end
      w_valid_nx = 1'b1;
      w_col_nx   = {COL_W{1'b0}};
    end else if (r_valid && ready_in) begin
      if (r_col == COL_LAST) begin
        w_valid_nx = 1'b0;
        w_col_nx   = {COL_W{1'b0}};
      end else begin
        w_col_nx   = r_col + COL_W'(1);
      end
    end else begin
      w_valid_nx = r_valid;
    end
  end

  // Scan sequencer registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_valid <= 1'b0;
      r_col   <= {COL_W{1'b0}};
      r_col2  <= COL2_OFS;
      r_ovr   <= 16'd0;
    end else begin
      r_valid <= w_valid_nx;
      r_col   <= w_col_nx;
      r_col2  <= {1'b0, w_col_nx} + COL2_OFS;
      r_ovr   <= w_ovr_nx;
    end
  end

  assign theta         = r_theta;
  assign col_num1      = r_col;
  assign col_num2      = r_col2;
  assign valid         = r_valid;
  assign slice_start   = r_slice_start;
  assign locked        = r_locked;
  assign overrun_count = r_ovr;

endmodule

// File: tb/tb_pov_slice_scheduler.sv
// Bench for pov_slice_scheduler: vector table of hall periods/ready patterns, a
// column-beat scoreboard, and hand sequences for period change, late index, loss and reset.
module tb_pov_slice_scheduler;

  localparam int RES  = 180;
  localparam int SCAN = 32;
  localparam int THW  = 27;
  localparam int CW   = 13;

  logic            clk_in = 1'b0;
  logic            rst_in = 1'b1;
  logic            hall_in = 1'b0;
  logic            ready_in = 1'b0;
  logic [THW-1:0]  theta;
  logic [4:0]      col_num1;
  logic [5:0]      col_num2;
  logic            valid;
  logic            slice_start;
  logic            locked;
  logic [15:0]     overrun_count;

  pov_slice_scheduler #(
    .ROTATIONAL_RES(RES),
    .SCAN_RATE(SCAN),
    .THETA_RES(THW),
    .CNT_W(CW)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .hall_in(hall_in),
    .ready_in(ready_in),
    .theta(theta),
    .col_num1(col_num1),
    .col_num2(col_num2),
    .valid(valid),
    .slice_start(slice_start),
    .locked(locked),
    .overrun_count(overrun_count)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int period;
    int rdy_every;
    int exp_len;
    int ovr_flag;
  } vec_t;

  vec_t vecs[6];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int hall_en  = 0;
  int rise_base = 0;
  int hall_period = 1;
  int rdy_every = 1;

  logic       m_valid = 1'b0;
  logic [4:0] m_col   = 5'd0;
  int         m_ovr   = 0;
  logic [4:0] sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // One clock: drive inputs at negedge, check beats and advance the scan model after posedge.
  task automatic step();
    logic       pv;
    logic       pss;
    logic [4:0] pc;
    logic [5:0] pc2;
    logic [4:0] ec;
    @(negedge clk_in);
    hall_in  = (hall_en != 0) && (cyc + 1 >= rise_base) &&
               (((cyc + 1 - rise_base) % hall_period) < 3);
    ready_in = (((cyc + 1) % rdy_every) == 0);
    if (m_valid && ready_in) sb.push_back(m_col);
    pv  = valid;
    pss = slice_start;
    pc  = col_num1;
    pc2 = col_num2;
    @(posedge clk_in);
    cyc++;
    #1;
    if ((pv && ready_in) || (sb.size() > 0)) begin
      if (pv && ready_in && (sb.size() > 0)) begin
        ec = sb.pop_front();
        chk("beat_col1", pc, ec);
        chk("beat_col2", pc2, {1'b0, ec} + 6'd32);
      end else begin
        chk("beat_present", pv && ready_in, sb.size() > 0);
        sb.delete();
      end
    end
    if (rst_in) begin
      m_valid = 1'b0;
      m_col   = 5'd0;
      m_ovr   = 0;
    end else if (pss) begin
      if (m_valid && !(ready_in && (m_col == 5'd31)) && (m_ovr < 65535)) m_ovr++;
      m_valid = 1'b1;
      m_col   = 5'd0;
    end else if (m_valid && ready_in) begin
      if (m_col == 5'd31) m_valid = 1'b0;
      else                m_col   = m_col + 5'd1;
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic do_reset();
    hall_en = 0;
    rst_in  = 1'b1;
    step();
    step();
    rst_in  = 1'b0;
  endtask

  // Reset, send two index pulses p apart and check lock lands CW cycles after the second.
  task automatic lock_at(input int p, input int every, output int r2);
    do_reset();
    rdy_every   = every;
    hall_period = p;
    rise_base   = cyc + 3;
    hall_en     = 1;
    r2          = rise_base + p;
    run_to(r2 + CW - 1);
    chk("prelock_locked", locked, 0);
    step();
    chk("lock_locked", locked, 1);
    chk("lock_theta", theta, 0);
    chk("lock_ss", slice_start, 1);
  endtask

  task automatic run_vec(input int id);
    int r2;
    int len;
    len = vecs[id].exp_len;
    lock_at(vecs[id].period, vecs[id].rdy_every, r2);
    chk("lock_ovr", overrun_count, 0);
    for (int k = 1; k <= 8 * len + 1; k++) begin
      step();
      chk("win_theta", theta, k / len);
      chk("win_ss", slice_start, (k % len) == 0);
    end
    chk("win_ovr", overrun_count, 8 * vecs[id].ovr_flag);
    chk("win_ovr_model", overrun_count, m_ovr);
  endtask

  initial begin
    int r2;
    int lk;
    int r3;
    int nss;

    vecs[0] = '{period: 3600, rdy_every: 1, exp_len: 20, ovr_flag: 1};
    vecs[1] = '{period: 3600, rdy_every: 4, exp_len: 20, ovr_flag: 1};
    vecs[2] = '{period: 7200, rdy_every: 1, exp_len: 40, ovr_flag: 0};
    vecs[3] = '{period: 5760, rdy_every: 1, exp_len: 32, ovr_flag: 0};
    vecs[4] = '{period: 5580, rdy_every: 1, exp_len: 31, ovr_flag: 1};
    vecs[5] = '{period: 100,  rdy_every: 1, exp_len: 1,  ovr_flag: 1};

    do_reset();
    chk("rst_theta", theta, 0);
    chk("rst_col1", col_num1, 0);
    chk("rst_col2", col_num2, 32);
    chk("rst_valid", valid, 0);
    chk("rst_ss", slice_start, 0);
    chk("rst_locked", locked, 0);
    chk("rst_ovr", overrun_count, 0);

    for (int i = 0; i < 6; i++) run_vec(i);

    // Period halves mid-run: forced theta 0, new length from the boundary after the divide.
    lock_at(3600, 1, r2);
    lk = cyc;
    rise_base   = r2 + 1800;
    hall_period = 1800;
    r3 = r2 + 1800;
    run_to(r3 - 1);
    chk("short_pre_theta", theta, (r3 - 1 - lk) / 20);
    step();
    chk("short_rise_theta", theta, 0);
    chk("short_rise_ss", slice_start, 1);
    run_to(r3 + 19);
    chk("short_19_theta", theta, 0);
    step();
    chk("short_20_theta", theta, 1);
    chk("short_20_ss", slice_start, 1);
    run_to(r3 + 29);
    chk("short_29_theta", theta, 1);
    step();
    chk("short_30_theta", theta, 2);
    chk("short_30_ss", slice_start, 1);
    run_to(r3 + 40);
    chk("short_40_theta", theta, 3);

    // Late index: theta parks at the last slice until the rise.
    lock_at(3600, 1, r2);
    lk = cyc;
    rise_base   = r2 + 4000;
    hall_period = 4000;
    run_to(lk + 3580);
    chk("late_last_theta", theta, RES - 1);
    chk("late_last_ss", slice_start, 1);
    nss = 0;
    while (cyc < r2 + 3999) begin
      step();
      nss += int'(slice_start);
    end
    chk("late_hold_ss_count", nss, 0);
    chk("late_hold_theta", theta, RES - 1);
    step();
    chk("late_rise_theta", theta, 0);
    chk("late_rise_ss", slice_start, 1);

    // Index lost: counter runs to all-ones and lock drops.
    lock_at(3600, 1, r2);
    hall_en = 0;
    run_to(r2 + (1 << CW) - 1);
    chk("loss_pre_locked", locked, 1);
    chk("loss_pre_theta", theta, RES - 1);
    step();
    chk("loss_locked", locked, 0);
    chk("loss_valid", valid, 0);
    chk("loss_theta", theta, 0);
    step();
    chk("loss_ss", slice_start, 0);

    // Reset in the middle of a scan.
    lock_at(3600, 1, r2);
    lk = cyc;
    run_to(lk + 25);
    chk("mid_valid", valid, 1);
    chk("mid_col1", col_num1, 4);
    chk("mid_ovr", overrun_count, 1);
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    chk("mrst_theta", theta, 0);
    chk("mrst_col1", col_num1, 0);
    chk("mrst_col2", col_num2, 32);
    chk("mrst_valid", valid, 0);
    chk("mrst_ss", slice_start, 0);
    chk("mrst_locked", locked, 0);
    chk("mrst_ovr", overrun_count, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
